// File: rtl/grant_data_mux_if.sv
// Bundle of the requester, arbiter and downstream signals seen by grant_data_mux.
// Latency: none (wires only).
// Backpressure: carries out_valid/out_ready for the drain side and req_ack for the requester side.
//
// Ports/signals:
//   req_valid/req_data/req_ack      - per-port payload offer and one-cycle consume pulse
//   arb_grant/arb_select/arb_active - arbiter one-hot grant, select index, grant-valid flag
//   out_valid/out_ready/out_data/out_port - FIFO head handshake toward the shared resource
// Modports: master drives requests/grants/ready (environment); slave is the mux itself.
interface grant_data_mux_if #(
    parameter int NUM_PORTS  = 64,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);
    logic [NUM_PORTS-1:0]            req_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
    logic [NUM_PORTS-1:0]            req_ack;
    logic [NUM_PORTS-1:0]            arb_grant;
    logic [SEL_WIDTH-1:0]            arb_select;
    logic                            arb_active;
    logic                            out_valid;
    logic                            out_ready;
    logic [DATA_WIDTH-1:0]           out_data;
    logic [SEL_WIDTH-1:0]            out_port;

    modport master (
        output req_valid, req_data, arb_grant, arb_select, arb_active, out_ready,
        input  req_ack, out_valid, out_data, out_port
    );

    modport slave (
        input  req_valid, req_data, arb_grant, arb_select, arb_active, out_ready,
        output req_ack, out_valid, out_data, out_port
    );
endinterface

// File: rtl/grant_data_mux.sv
// Captures the arbiter-granted port's payload into a 2-entry in-order FIFO and acks the winner.
// Latency: grant in cycle N -> req_ack pulse and (if FIFO was empty) out_valid in cycle N+1.
// Backpressure: out_valid/out_ready drain; a grant arriving with the FIFO full and no pop is dropped, no ack.
//
// Ports:
//   clk, rstn - single rising-edge clock, asynchronous active-low reset
//   bus       - grant_data_mux_if.slave (requests, arbiter grant, output handshake)
//   grant_err - sticky: set by any inconsistent arbiter grant, cleared only by reset
//   stale_cnt, stall_cnt - 16-bit saturating statistics, present only when GRANT_MUX_STATS_EN is defined
module grant_data_mux #(
    parameter int NUM_PORTS  = 64,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    grant_data_mux_if.slave bus,
    output logic            grant_err
`ifdef GRANT_MUX_STATS_EN
    ,
    output logic [15:0]     stale_cnt,
    output logic [15:0]     stall_cnt
`endif
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic [SEL_WIDTH-1:0]  port;
    } entry_t;

    // Selected-port view (all zero when arb_select is out of range)
    logic                  sel_hit;
    logic                  sel_gnt;
    logic                  sel_vld;
    logic                  sel_pend;
    logic [DATA_WIDTH-1:0] sel_dat;

    logic grant_any;
    logic grant_onehot;
    logic grant_ok;
    logic elig;
    logic pop;
    logic room;
    logic push;

    entry_t               fifo_q [2];
    entry_t               fifo_d [2];
    logic [1:0]           cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic                 grant_err_q, grant_err_d;

    // Decode the select index once; a select beyond NUM_PORTS-1 simply finds no port,
    // which makes any active grant inconsistent.
    always_comb begin
        sel_hit  = 1'b0;
        sel_gnt  = 1'b0;
        sel_vld  = 1'b0;
        sel_pend = 1'b0;
        sel_dat  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.arb_select == SEL_WIDTH'(i)) begin
                sel_hit  = 1'b1;
                sel_gnt  = bus.arb_grant[i];
                sel_vld  = bus.req_valid[i];
                sel_pend = ack_q[i];
                sel_dat  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        grant_any    = |bus.arb_grant;
        grant_onehot = grant_any &&
                       ((bus.arb_grant & (bus.arb_grant - NUM_PORTS'(1))) == '0);
        grant_ok     = (bus.arb_active == grant_any) &&
                       (!grant_any || (grant_onehot && sel_hit && sel_gnt));
        elig         = grant_ok && bus.arb_active;
        pop          = (cnt_q != 2'd0) && bus.out_ready;
        // A full FIFO still has room when the head leaves in the same cycle.
        room         = (cnt_q != 2'd2) || pop;
        // A port whose ack is on the wire this cycle still shows the consumed payload.
        push         = elig && sel_vld && !sel_pend && room;
        grant_err_d  = grant_err_q || !grant_ok;
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            ack_d[i] = push && (bus.arb_select == SEL_WIDTH'(i));
        end
    end

    // Shift-style FIFO: entry 0 is always the head, so the output needs no read mux.
    always_comb begin
        fifo_d = fifo_q;
        cnt_d  = cnt_q;
        if (pop) begin
            fifo_d[0] = fifo_q[1];
            cnt_d     = cnt_q - 2'd1;
        end
        if (push) begin
            if (cnt_d == 2'd0) begin
                fifo_d[0].dat  = sel_dat;
                fifo_d[0].port = bus.arb_select;
            end else begin
                fifo_d[1].dat  = sel_dat;
                fifo_d[1].port = bus.arb_select;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            cnt_q       <= 2'd0;
            ack_q       <= '0;
            grant_err_q <= 1'b0;
        end else begin
            fifo_q[0]   <= fifo_d[0];
            fifo_q[1]   <= fifo_d[1];
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign bus.req_ack   = ack_q;
    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_data  = fifo_q[0].dat;
    assign bus.out_port  = fifo_q[0].port;
    assign grant_err     = grant_err_q;

`ifdef GRANT_MUX_STATS_EN
    logic        stale;
    logic        stall;
    logic [15:0] stale_cnt_q, stale_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stale       = elig && (!sel_vld || sel_pend);
        stall       = elig && sel_vld && !sel_pend && !room;
        stale_cnt_d = stale_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (stale && (stale_cnt_q != 16'hFFFF)) stale_cnt_d = stale_cnt_q + 16'd1;
        if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stale_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            stale_cnt_q <= stale_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stale_cnt = stale_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_grant_data_mux.sv
// Self-checking bench for grant_data_mux: directed vector table, hand-written corner
// sequences (single-port re-grant, async reset mid-traffic, out-of-grant select) and a
// randomized phase checked against a queue-based reference model.
module tb_grant_data_mux;
    localparam int NP = 64;
    localparam int DW = 32;
    localparam int SW = 6;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    grant_data_mux_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();
    grant_data_mux_if #(.NUM_PORTS(1),  .DATA_WIDTH(DW), .SEL_WIDTH(1))  bus1 ();

    logic err64, err1;
`ifdef GRANT_MUX_STATS_EN
    logic [15:0] stale64, stall64, stale1, stall1;
`endif

    grant_data_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .grant_err (err64)
`ifdef GRANT_MUX_STATS_EN
        ,
        .stale_cnt (stale64),
        .stall_cnt (stall64)
`endif
    );

    grant_data_mux #(.NUM_PORTS(1), .DATA_WIDTH(DW), .SEL_WIDTH(1)) dut1 (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus1),
        .grant_err (err1)
`ifdef GRANT_MUX_STATS_EN
        ,
        .stale_cnt (stale1),
        .stall_cnt (stall1)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] dat;
        int          port;
    } ent_t;

    ent_t mq[$];
    int   m_ack;
    bit   m_err;
    int   m_stale, m_stall;

    function automatic void model_reset();
        mq.delete();
        m_ack   = -1;
        m_err   = 1'b0;
        m_stale = 0;
        m_stall = 0;
    endfunction

    // Evaluate one clock edge from the inputs currently applied to bus.
    function automatic void model_step();
        int   ones;
        int   s;
        bit   cons, pop, room, cap;
        ent_t e;
        ones = $countones(bus.arb_grant);
        s    = int'(bus.arb_select);
        cons = (bus.arb_active == (ones != 0)) &&
               ((ones == 0) || ((ones == 1) && bus.arb_grant[s]));
        pop  = (mq.size() > 0) && bus.out_ready;
        room = (mq.size() < 2) || pop;
        cap  = 1'b0;
        if (!cons) m_err = 1'b1;
        else if (bus.arb_active) begin
            if (!bus.req_valid[s] || (m_ack == s)) begin
                if (m_stale < 65535) m_stale++;
            end else if (!room) begin
                if (m_stall < 65535) m_stall++;
            end else cap = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        if (cap) begin
            e.dat  = bus.req_data[s*DW +: DW];
            e.port = s;
            mq.push_back(e);
        end
        m_ack = cap ? s : -1;
    endfunction

    task automatic model_compare(input int cyc);
        logic [63:0] exp_ack;
        exp_ack = (m_ack >= 0) ? (64'd1 << m_ack) : 64'd0;
        chk($sformatf("rnd%0d ack", cyc), bus.req_ack, exp_ack);
        chk($sformatf("rnd%0d out_valid", cyc), bus.out_valid, (mq.size() > 0));
        if (mq.size() > 0) begin
            chk($sformatf("rnd%0d out_data", cyc), bus.out_data, mq[0].dat);
            chk($sformatf("rnd%0d out_port", cyc), bus.out_port, mq[0].port);
        end
        chk($sformatf("rnd%0d grant_err", cyc), err64, m_err);
`ifdef GRANT_MUX_STATS_EN
        chk($sformatf("rnd%0d stale_cnt", cyc), stale64, m_stale);
        chk($sformatf("rnd%0d stall_cnt", cyc), stall64, m_stall);
`endif
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid  = '0;
        for (int i = 0; i < NP; i++) bus.req_data[i*DW +: DW] = 32'hBB00_0000 | i;
        bus.arb_grant  = '0;
        bus.arb_select = '0;
        bus.arb_active = 1'b0;
        bus.out_ready  = 1'b0;
        bus1.req_valid  = '0;
        bus1.req_data   = '0;
        bus1.arb_grant  = '0;
        bus1.arb_select = '0;
        bus1.arb_active = 1'b0;
        bus1.out_ready  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " ack"},       bus.req_ack, 64'd0);
        chk({tag, " out_valid"}, bus.out_valid, 1'b0);
        chk({tag, " out_data"},  bus.out_data, 32'd0);
        chk({tag, " out_port"},  bus.out_port, 6'd0);
        chk({tag, " grant_err"}, err64, 1'b0);
        chk({tag, " p1 valid"},  bus1.out_valid, 1'b0);
`ifdef GRANT_MUX_STATS_EN
        chk({tag, " stale_cnt"}, stale64, 16'd0);
        chk({tag, " stall_cnt"}, stall64, 16'd0);
`endif
    endtask

    // Asynchronous assertion in mid-cycle; release one edge later.
    task automatic do_reset(input string tag);
        #2;
        rstn = 1'b0;
        idle();
        #1;
        check_reset_state(tag);
        tick();
        rstn = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [63:0] vld;
        logic [31:0] dat;
        logic [63:0] gnt;
        logic [5:0]  sel;
        logic        act;
        logic        rdy;
        logic [63:0] e_ack;
        logic        e_vld;
        logic [31:0] e_dat;
        logic [5:0]  e_port;
        logic        e_err;
        int          e_stale;
        int          e_stall;
    } vec_t;

    function automatic vec_t mk(input logic [63:0] vld, input logic [31:0] dat,
                                input logic [63:0] gnt, input logic [5:0] sel,
                                input logic act, input logic rdy,
                                input logic [63:0] e_ack, input logic e_vld,
                                input logic [31:0] e_dat, input logic [5:0] e_port,
                                input logic e_err, input int e_stale, input int e_stall);
        vec_t v;
        v.vld = vld; v.dat = dat; v.gnt = gnt; v.sel = sel; v.act = act; v.rdy = rdy;
        v.e_ack = e_ack; v.e_vld = e_vld; v.e_dat = e_dat; v.e_port = e_port;
        v.e_err = e_err; v.e_stale = e_stale; v.e_stall = e_stall;
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        logic [63:0] one;
        int          r;
        int          s;
        one = 64'd1;

        tbl[0]  = mk(one<<3, 32'hA5A5_0003, one<<3, 6'd3, 1, 0, one<<3, 1, 32'hA5A5_0003, 6'd3, 0, 0, 0);
        tbl[1]  = mk(64'd0,  32'h0,         64'd0,  6'd0, 0, 1, 64'd0,  0, 32'h0,         6'd0, 0, 0, 0);
        tbl[2]  = mk(one<<0, 32'hD000_0000, one<<0, 6'd0, 1, 0, one<<0, 1, 32'hD000_0000, 6'd0, 0, 0, 0);
        tbl[3]  = mk(one<<1, 32'hD111_1111, one<<1, 6'd1, 1, 0, one<<1, 1, 32'hD000_0000, 6'd0, 0, 0, 0);
        tbl[4]  = mk(one<<2, 32'hD222_2222, one<<2, 6'd2, 1, 0, 64'd0,  1, 32'hD000_0000, 6'd0, 0, 0, 1);
        tbl[5]  = mk(one<<2, 32'h5555_5555, one<<5, 6'd5, 1, 0, 64'd0,  1, 32'hD000_0000, 6'd0, 0, 1, 1);
        tbl[6]  = mk(one<<2, 32'hD222_2222, one<<2, 6'd2, 1, 1, one<<2, 1, 32'hD111_1111, 6'd1, 0, 1, 1);
        tbl[7]  = mk(64'd0,  32'h0,         64'd0,  6'd0, 0, 1, 64'd0,  1, 32'hD222_2222, 6'd2, 0, 1, 1);
        tbl[8]  = mk(64'd0,  32'h0,         64'd0,  6'd0, 0, 1, 64'd0,  0, 32'h0,         6'd0, 0, 1, 1);
        tbl[9]  = mk(~64'd0, 32'hEEEE_EEEE, 64'h6,  6'd1, 1, 0, 64'd0,  0, 32'h0,         6'd0, 1, 1, 1);
        tbl[10] = mk(64'd0,  32'h0,         64'd0,  6'd0, 0, 0, 64'd0,  0, 32'h0,         6'd0, 1, 1, 1);

        idle();
        do_reset("reset0");

        for (int k = 0; k < 11; k++) begin
            idle();
            bus.req_valid = tbl[k].vld;
            bus.req_data[int'(tbl[k].sel)*DW +: DW] = tbl[k].dat;
            bus.arb_grant  = tbl[k].gnt;
            bus.arb_select = tbl[k].sel;
            bus.arb_active = tbl[k].act;
            bus.out_ready  = tbl[k].rdy;
            tick();
            chk($sformatf("vec%0d ack", k), bus.req_ack, tbl[k].e_ack);
            chk($sformatf("vec%0d out_valid", k), bus.out_valid, tbl[k].e_vld);
            if (tbl[k].e_vld) begin
                chk($sformatf("vec%0d out_data", k), bus.out_data, tbl[k].e_dat);
                chk($sformatf("vec%0d out_port", k), bus.out_port, tbl[k].e_port);
            end
            chk($sformatf("vec%0d grant_err", k), err64, tbl[k].e_err);
`ifdef GRANT_MUX_STATS_EN
            chk($sformatf("vec%0d stale_cnt", k), stale64, tbl[k].e_stale);
            chk($sformatf("vec%0d stall_cnt", k), stall64, tbl[k].e_stall);
`endif
        end

        // Async reset with two entries queued, an ack on the wire and grant_err set.
        idle();
        bus.req_valid  = 64'h30;
        bus.arb_grant  = one << 4;
        bus.arb_select = 6'd4;
        bus.arb_active = 1'b1;
        tick();
        bus.arb_grant  = one << 5;
        bus.arb_select = 6'd5;
        tick();
        chk("prerst out_valid", bus.out_valid, 1'b1);
        chk("prerst ack", bus.req_ack, one << 5);
        do_reset("midrst");

        // Grant bit and select disagree.
        idle();
        bus.req_valid  = ~64'd0;
        bus.arb_grant  = one << 4;
        bus.arb_select = 6'd2;
        bus.arb_active = 1'b1;
        tick();
        chk("selmis grant_err", err64, 1'b1);
        chk("selmis ack", bus.req_ack, 64'd0);
        chk("selmis out_valid", bus.out_valid, 1'b0);

        // Single-port instance: back-to-back grants to the same port.
        do_reset("reset1");
        bus1.req_valid  = 1'b1;
        bus1.req_data   = 32'h1111_2222;
        bus1.arb_grant  = 1'b1;
        bus1.arb_select = 1'b0;
        bus1.arb_active = 1'b1;
        tick();
        chk("p1 first ack", bus1.req_ack, 1'b1);
        chk("p1 first valid", bus1.out_valid, 1'b1);
        chk("p1 first data", bus1.out_data, 32'h1111_2222);
        tick();
        chk("p1 second ack", bus1.req_ack, 1'b0);
        chk("p1 second valid", bus1.out_valid, 1'b1);
        chk("p1 grant_err", err1, 1'b0);
`ifdef GRANT_MUX_STATS_EN
        chk("p1 stale_cnt", stale1, 16'd1);
`endif
        bus1.req_valid  = 1'b0;
        bus1.arb_grant  = 1'b0;
        bus1.arb_active = 1'b0;
        bus1.out_ready  = 1'b1;
        tick();
        chk("p1 drained", bus1.out_valid, 1'b0);

        // Randomized phase against the reference model.
        do_reset("reset2");
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset("rndrst");
            bus.req_valid = {$urandom, $urandom};
            for (int i = 0; i < NP; i++) bus.req_data[i*DW +: DW] = $urandom;
            r = $urandom_range(0, 99);
            if (r < 20) begin
                bus.arb_grant  = '0;
                bus.arb_select = 6'($urandom_range(0, 63));
                bus.arb_active = 1'b0;
            end else if (r < 95 || c < 2000) begin
                s = $urandom_range(0, 7);
                bus.arb_grant  = one << s;
                bus.arb_select = 6'(s);
                bus.arb_active = 1'b1;
            end else begin
                bus.arb_grant  = (one << $urandom_range(0, 63)) | (one << $urandom_range(0, 63));
                bus.arb_select = 6'($urandom_range(0, 63));
                bus.arb_active = 1'($urandom_range(0, 1));
            end
            bus.out_ready = ($urandom_range(0, 2) == 0);
            model_step();
            tick();
            model_compare(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
